// File: rtl/lc2k_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_pkg
// Description : LC2K datapath defaults, operand-B select codes and the
//               offset sign-extension helper.
// Revision    : 1.0  initial release
// ============================================================================
package lc2k_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 3;
    localparam int OFF_W      = 16;

    localparam logic ALUVALB_OFFSET = 1'b0;
    localparam logic ALUVALB_REGB   = 1'b1;

    // Widest result sext_offset can build; callers slice down to their width.
    localparam int SEXT_MAX_W = 64;

    // Replicates raw[signPos] into every bit above signPos.
    function automatic logic [SEXT_MAX_W-1:0] sext_offset(
        input logic [SEXT_MAX_W-1:0] raw,
        input logic [5:0]            signPos
    );
        logic [SEXT_MAX_W-1:0] r;
        logic                  s;
        r = raw;
        s = raw[signPos];
        for (int i = 0; i < SEXT_MAX_W; i++) begin
            if (i > int'(signPos)) begin
                r[i] = s;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Priority forwarding mux; source 0 is youngest and wins.
// Revision    : 1.0  initial release
// ============================================================================
module fwd_select
    import lc2k_pkg::*;
#(
    parameter int DATA_W     = lc2k_pkg::DATA_W,
    parameter int REG_ADDR_W = lc2k_pkg::REG_ADDR_W,
    parameter int NUM_FWD    = 3
) (
    input  logic [REG_ADDR_W-1:0]         idx,
    input  logic [DATA_W-1:0]             rfVal,
    input  logic [NUM_FWD-1:0]            fwdValid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwdDest,
    input  logic [NUM_FWD*DATA_W-1:0]     fwdData,
    output logic [DATA_W-1:0]             val,
    output logic                          hit
);

    logic w_notZero;

    assign w_notZero = (idx != '0);

    // Walk from oldest to youngest so the lowest matching index lands last.
    always_comb begin
        val = rfVal;
        hit = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_notZero && fwdValid[i] &&
                (fwdDest[i*REG_ADDR_W +: REG_ADDR_W] == idx)) begin
                val = fwdData[i*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Registered ALU operand select with RAW forwarding on A and B.
//               Optional forward-hit counter under ALU_OPERAND_FWD_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage
    import lc2k_pkg::*;
#(
    parameter int DATA_W     = lc2k_pkg::DATA_W,
    parameter int OFF_W      = lc2k_pkg::OFF_W,
    parameter int REG_ADDR_W = lc2k_pkg::REG_ADDR_W,
    parameter int NUM_FWD    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_stall,
    input  logic                          in_flush,
    input  logic                          ctrl_alu_valb,
    input  logic [REG_ADDR_W-1:0]         rega_idx,
    input  logic [REG_ADDR_W-1:0]         regb_idx,
    input  logic [DATA_W-1:0]             rega_val,
    input  logic [DATA_W-1:0]             regb_val,
    input  logic [OFF_W-1:0]              offset,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
`ifdef ALU_OPERAND_FWD_CNT_EN
    output logic [31:0]                   fwd_hit_cnt,
`endif
    output logic                          out_valid,
    output logic [DATA_W-1:0]             alu_val_a,
    output logic [DATA_W-1:0]             alu_val_b,
    output logic [DATA_W-1:0]             store_data
);

    localparam logic [5:0] SIGN_POS = 6'(OFF_W - 1);

    logic [DATA_W-1:0]     w_fwdA;
    logic [DATA_W-1:0]     w_fwdB;
    logic                  w_hitA;
    logic                  w_hitB;
    logic [SEXT_MAX_W-1:0] w_sextFull;
    logic [DATA_W-1:0]     w_sext;
    logic [DATA_W-1:0]     w_opB;
    logic                  w_load;

    logic                  r_outValid;
    logic [DATA_W-1:0]     r_aluValA;
    logic [DATA_W-1:0]     r_aluValB;
    logic [DATA_W-1:0]     r_storeData;

    fwd_select #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_FWD   (NUM_FWD)
    ) u_fwdA (
        .idx     (rega_idx),
        .rfVal   (rega_val),
        .fwdValid(fwd_valid),
        .fwdDest (fwd_dest),
        .fwdData (fwd_data),
        .val     (w_fwdA),
        .hit     (w_hitA)
    );

    fwd_select #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_FWD   (NUM_FWD)
    ) u_fwdB (
        .idx     (regb_idx),
        .rfVal   (regb_val),
        .fwdValid(fwd_valid),
        .fwdDest (fwd_dest),
        .fwdData (fwd_data),
        .val     (w_fwdB),
        .hit     (w_hitB)
    );

    assign w_sextFull = sext_offset({{(SEXT_MAX_W-OFF_W){1'b0}}, offset}, SIGN_POS);
    assign w_sext     = w_sextFull[DATA_W-1:0];
    assign w_opB      = (ctrl_alu_valb == ALUVALB_REGB) ? w_fwdB : w_sext;
    assign w_load     = rst_n && !in_flush && !in_stall && in_valid;

    // Flush only drops valid; data outputs keep their last loaded value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_aluValA   <= '0;
            r_aluValB   <= '0;
            r_storeData <= '0;
        end else if (in_flush) begin
            r_outValid <= 1'b0;
        end else if (!in_stall) begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_aluValA   <= w_fwdA;
                r_aluValB   <= w_opB;
                r_storeData <= w_fwdB;
            end
        end
    end

    assign out_valid  = r_outValid;
    assign alu_val_a  = r_aluValA;
    assign alu_val_b  = r_aluValB;
    assign store_data = r_storeData;

`ifdef ALU_OPERAND_FWD_CNT_EN
    logic [31:0] r_fwdHitCnt;
    logic [1:0]  w_hitInc;
    logic [32:0] w_cntSum;

    // B only counts when it actually feeds the ALU.
    assign w_hitInc = {1'b0, w_hitA} + {1'b0, w_hitB & (ctrl_alu_valb == ALUVALB_REGB)};
    assign w_cntSum = {1'b0, r_fwdHitCnt} + {31'b0, w_hitInc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwdHitCnt <= '0;
        end else if (w_load) begin
            r_fwdHitCnt <= w_cntSum[32] ? 32'hFFFF_FFFF : w_cntSum[31:0];
        end
    end

    assign fwd_hit_cnt = r_fwdHitCnt;
`else
    logic w_unusedLoad;
    assign w_unusedLoad = w_load;
`endif

endmodule
`default_nettype wire
